// File: rtl/led_pkg.sv
// Shared definitions for the LED board brightness path: FSM encoding,
// default duty code width and the flat duty bus packing helper.
package led_pkg;

    // Width of one duty code; the downstream PWM stage uses the same value.
    localparam int DUTY_W = 3;

    // Breathing sequencer states (3-bit encoding visible on the debug port).
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    // Returns bit 'idx' of the flat duty bus, where channel ch occupies
    // bits [ch*w +: w]. bar=0 gives every channel the level itself;
    // bar=1 lights channels below the level at full code, the rest at 0.
    // Working bit by bit keeps the helper independent of bus width.
    function automatic logic flat_duty_bit(
        input int   idx,
        input int   w,
        input int   lvl,
        input logic bar,
        input int   duty_max
    );
        int ch;
        int code;
        int sh;
        ch = idx / w;
        if (bar) code = (lvl > ch) ? duty_max : 0;
        else     code = lvl;
        sh = code >> (idx % w);
        return sh[0];
    endfunction

endpackage

// File: rtl/led_duty_sequencer_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
// Dropping en restarts the count, so a fresh full period follows re-enable.
module tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count 0..TICK_DIV-1 while enabled; hold at 0 while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (!en)         cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_duty_sequencer.sv
// Breathing brightness sequencer: ramps a level 0..DUTY_MAX up and down with
// optional holds at the extremes, one step per prescaler tick, and maps the
// level to a registered per-LED duty code bus for the PWM stage.
module led_duty_sequencer
    import led_pkg::*;
#(
    parameter int LED_COUNT  = 6,
    parameter int DUTY_W     = led_pkg::DUTY_W,
    parameter int DUTY_MAX   = 6,
    parameter int TICK_DIV   = 1000000,
    parameter int HOLD_STEPS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        mode,
    output logic [LED_COUNT*DUTY_W-1:0] duty,
    output logic                        step_strobe,
    output logic [2:0]                  state
);

    localparam int BUS_W = LED_COUNT * DUTY_W;
    localparam int LVL_W = (DUTY_MAX > 1) ? $clog2(DUTY_MAX + 1) : 1;
    localparam int HC_W  = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(DUTY_MAX);
    localparam logic [LVL_W-1:0] LVL_PRE  = LVL_W'(DUTY_MAX - 1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    // With no hold configured the ramps turn around directly at the extremes.
    localparam state_t TOP_NEXT = (HOLD_STEPS > 0) ? HOLD_HIGH : RAMP_DOWN;
    localparam state_t BOT_NEXT = (HOLD_STEPS > 0) ? HOLD_LOW  : RAMP_UP;

    logic             tick;
    state_t           st_q,   st_n;
    logic [LVL_W-1:0] lvl_q,  lvl_n;
    logic [HC_W-1:0]  hc_q,   hc_n;
    logic             mode_q, mode_n;
    logic [BUS_W-1:0] duty_n;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    assign state = st_q;

    // Next-state, next-level and next duty bus; everything advances only on tick.
    always_comb begin
        st_n   = st_q;
        lvl_n  = lvl_q;
        hc_n   = hc_q;
        mode_n = mode_q;
        if (tick) begin
            mode_n = mode;
            case (st_q)
                IDLE: begin
                    lvl_n = LVL_ONE;
                    st_n  = RAMP_UP;
                end
                RAMP_UP: begin
                    if (lvl_q < LVL_PRE) begin
                        lvl_n = lvl_q + 1'b1;
                    end else begin
                        lvl_n = LVL_TOP;
                        st_n  = TOP_NEXT;
                    end
                end
                HOLD_HIGH: begin
                    if (hc_q == HC_LAST) begin
                        hc_n = '0;
                        st_n = RAMP_DOWN;
                    end else begin
                        hc_n = hc_q + 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (lvl_q > LVL_ONE) begin
                        lvl_n = lvl_q - 1'b1;
                    end else begin
                        lvl_n = '0;
                        st_n  = BOT_NEXT;
                    end
                end
                HOLD_LOW: begin
                    if (hc_q == HC_LAST) begin
                        hc_n = '0;
                        st_n = RAMP_UP;
                    end else begin
                        hc_n = hc_q + 1'b1;
                    end
                end
                default: begin
                    st_n  = IDLE;
                    lvl_n = '0;
                    hc_n  = '0;
                end
            endcase
        end
        // Map the upcoming level with the mode being sampled this tick.
        for (int b = 0; b < BUS_W; b++) begin
            duty_n[b] = flat_duty_bit(b, DUTY_W, 32'(lvl_n), mode_n, DUTY_MAX);
        end
    end

    // State registers; duty only changes on tick so the PWM sees stable codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= IDLE;
            lvl_q       <= '0;
            hc_q        <= '0;
            mode_q      <= 1'b0;
            duty        <= '0;
            step_strobe <= 1'b0;
        end else begin
            st_q        <= st_n;
            lvl_q       <= lvl_n;
            hc_q        <= hc_n;
            mode_q      <= mode_n;
            step_strobe <= tick;
            if (tick) duty <= duty_n;
        end
    end

endmodule

// File: tb/tb_led_duty_sequencer.sv
// Directed bench for led_duty_sequencer with TICK_DIV=4, DUTY_MAX=6,
// LED_COUNT=6: a main DUT with HOLD_STEPS=2 and a second with HOLD_STEPS=0.
// Cycle k means the interval after the k-th rising edge following reset
// release; outputs are sampled on falling edges.
module tb_led_duty_sequencer;
    import led_pkg::*;

    localparam int NL = 6;
    localparam int DW = 3;
    localparam int BW = NL * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, mode;
    logic [BW-1:0] duty;
    logic          step_strobe;
    logic [2:0]    state;

    logic          rst0, en0, mode0;
    logic [BW-1:0] duty0;
    logic          strobe0;
    logic [2:0]    state0;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    typedef struct {
        int            cyc;
        logic          en;
        logic          mode;
        logic [BW-1:0] duty;
        logic          strobe;
        logic [2:0]    st;
    } row_t;

    row_t rows[$];

    led_duty_sequencer #(
        .LED_COUNT (NL), .DUTY_W (DW), .DUTY_MAX (6), .TICK_DIV (4), .HOLD_STEPS (2)
    ) dut (
        .clk (clk), .rst (rst), .en (en), .mode (mode),
        .duty (duty), .step_strobe (step_strobe), .state (state)
    );

    led_duty_sequencer #(
        .LED_COUNT (NL), .DUTY_W (DW), .DUTY_MAX (6), .TICK_DIV (4), .HOLD_STEPS (0)
    ) dut0 (
        .clk (clk), .rst (rst0), .en (en0), .mode (mode0),
        .duty (duty0), .step_strobe (strobe0), .state (state0)
    );

    function automatic logic [BW-1:0] all_of(input int v);
        logic [BW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [BW-1:0] bar_of(input int lvl);
        logic [BW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = (lvl > i) ? 3'd6 : 3'd0;
        return r;
    endfunction

    task automatic chk(input string nm,
                       input logic [BW-1:0] gd, input logic gs, input logic [2:0] gst,
                       input logic [BW-1:0] ed, input logic es, input logic [2:0] est);
        total += 3;
        if (gd !== ed) begin
            bad++;
            $display("FAIL %s duty got=%o want=%o", nm, gd, ed);
        end
        if (gs !== es) begin
            bad++;
            $display("FAIL %s step_strobe got=%b want=%b", nm, gs, es);
        end
        if (gst !== est) begin
            bad++;
            $display("FAIL %s state got=%0d want=%0d", nm, gst, est);
        end
    endtask

    task automatic add(input int c, input logic e, input logic m,
                       input logic [BW-1:0] d, input logic s, input logic [2:0] st);
        row_t r;
        r.cyc = c; r.en = e; r.mode = m; r.duty = d; r.strobe = s; r.st = st;
        rows.push_back(r);
    endtask

    // Each row: advance to its cycle, compare, then drive its inputs.
    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            repeat (rows[r].cyc - cur) @(negedge clk);
            cur = rows[r].cyc;
            chk($sformatf("row%0d_c%0d", r, rows[r].cyc), duty, step_strobe, state,
                rows[r].duty, rows[r].strobe, rows[r].st);
            en   = rows[r].en;
            mode = rows[r].mode;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0;
        rst0 = 1'b1; en0 = 1'b1; mode0 = 1'b0;

        // first ramp (rows 0..5)
        add(0,   1, 0, all_of(0), 0, IDLE);
        add(3,   1, 0, all_of(0), 0, IDLE);
        add(4,   1, 0, all_of(1), 1, RAMP_UP);
        add(5,   1, 0, all_of(1), 0, RAMP_UP);
        add(23,  1, 0, all_of(5), 0, RAMP_UP);
        add(24,  1, 0, all_of(6), 1, HOLD_HIGH);
        // hold, ramp down, low hold, restart (rows 6..14)
        add(28,  1, 0, all_of(6), 1, HOLD_HIGH);
        add(32,  1, 0, all_of(6), 1, RAMP_DOWN);
        add(36,  1, 0, all_of(5), 1, RAMP_DOWN);
        add(56,  1, 0, all_of(0), 1, HOLD_LOW);
        add(60,  1, 0, all_of(0), 1, HOLD_LOW);
        add(64,  1, 0, all_of(0), 1, RAMP_UP);
        add(67,  1, 0, all_of(0), 0, RAMP_UP);
        add(68,  1, 0, all_of(1), 1, RAMP_UP);
        add(72,  1, 0, all_of(2), 1, RAMP_UP);
        // en low c73..c83 at lvl=2, then bar mode at lvl=3 (rows 15..24)
        add(73,  0, 0, all_of(2), 0, RAMP_UP);
        add(77,  0, 0, all_of(2), 0, RAMP_UP);
        add(83,  1, 0, all_of(2), 0, RAMP_UP);
        add(84,  1, 1, all_of(2), 0, RAMP_UP);
        add(86,  1, 1, all_of(2), 0, RAMP_UP);
        add(87,  1, 1, bar_of(3), 1, RAMP_UP);
        add(88,  1, 0, bar_of(3), 0, RAMP_UP);
        add(89,  1, 1, bar_of(3), 0, RAMP_UP);
        add(90,  1, 0, bar_of(3), 0, RAMP_UP);
        add(91,  1, 0, all_of(4), 1, RAMP_UP);
        // into the second ramp down (rows 25..27)
        add(99,  1, 0, all_of(6), 1, HOLD_HIGH);
        add(107, 1, 0, all_of(6), 1, RAMP_DOWN);
        add(115, 1, 0, all_of(4), 1, RAMP_DOWN);

        repeat (2) @(negedge clk);
        chk("reset_state", duty, step_strobe, state, all_of(0), 1'b0, IDLE);

        rst = 1'b0;
        cur = 0;
        run_rows(0, 27);

        // async reset mid-ramp-down, in a strobe cycle, before the next clk edge
        #2 rst = 1'b1;
        #1 chk("async_reset", duty, step_strobe, state, all_of(0), 1'b0, IDLE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur = 0;
        run_rows(0, 5);

        // HOLD_STEPS=0 build
        @(negedge clk);
        rst0 = 1'b0;
        repeat (4)  @(negedge clk);
        chk("nohold_c4",  duty0, strobe0, state0, all_of(1), 1'b1, RAMP_UP);
        repeat (20) @(negedge clk);
        chk("nohold_c24", duty0, strobe0, state0, all_of(6), 1'b1, RAMP_DOWN);
        repeat (4)  @(negedge clk);
        chk("nohold_c28", duty0, strobe0, state0, all_of(5), 1'b1, RAMP_DOWN);
        repeat (20) @(negedge clk);
        chk("nohold_c48", duty0, strobe0, state0, all_of(0), 1'b1, RAMP_UP);
        repeat (4)  @(negedge clk);
        chk("nohold_c52", duty0, strobe0, state0, all_of(1), 1'b1, RAMP_UP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
